// File: rtl/onehot_strobe_decoder.sv
// onehot_strobe_decoder
//   Registered 3-to-8 decoder behind a valid/ready handshake. Each accepted
//   code drives the matching one-hot strobe on y for max(hold,1) cycles.
//   After the strobe, the block spends one GAP cycle with y=0 and done=1,
//   then returns to IDLE. Dropping enable during the strobe aborts it.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   enable     in   block enable; low masks acceptance, aborts a strobe
//   code       in   [2:0] index to decode (0 -> y[0], 7 -> y[7])
//   code_valid in   code/hold valid this cycle
//   code_ready out  block can accept a code this cycle (combinational)
//   hold       in   [HOLD_W-1:0] strobe length in cycles, 0 treated as 1
//   y          out  [7:0] registered one-hot strobe, zero when idle
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse after a normally completed strobe
module onehot_strobe_decoder #(
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [2:0]        code,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [HOLD_W-1:0] hold,
  output logic [7:0]        y,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            r_state;
  logic [7:0]        r_y;
  logic              r_done;
  logic [HOLD_W-1:0] r_cnt;
  logic              w_accept;
  logic [HOLD_W-1:0] w_load;

  // rst is included so ready drops immediately on an asynchronous reset,
  // even before the state register has been cleared by the flop.
  assign code_ready = (r_state == IDLE) & enable & ~rst;
  assign w_accept   = code_valid & code_ready;

  // Remaining DRIVE cycles after the first; hold=0 saturates to a single cycle.
  assign w_load = (hold == '0) ? '0 : hold - HOLD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_y    <= '0;
          r_done <= 1'b0;
          if (w_accept) begin
            r_y     <= 8'h01 << code;
            r_cnt   <= w_load;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          if (!enable) begin
            // Abort takes priority over completion: no done pulse.
            r_y     <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - HOLD_W'(1);
          end else begin
            r_y     <= '0;
            r_done  <= 1'b1;
            r_state <= GAP;
          end
        end
        GAP: begin
          r_y     <= '0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_y     <= '0;
          r_done  <= 1'b0;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign y    = r_y;
  assign done = r_done;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
module tb_onehot_strobe_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [3:0] hold;
  logic [7:0] y;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Observation vector: {y, busy, done, code_ready}
  logic [10:0] obs;
  assign obs = {y, busy, done, code_ready};

  onehot_strobe_decoder #(.HOLD_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .hold       (hold),
    .y          (y),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; code = 3'd0; code_valid = 1'b0; hold = 4'd0;
    #3;
    checks++;
    if (obs !== 11'h000) begin errors++; $display("FAIL reset_state: got %h want %h", obs, 11'h000); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL reset_release_ready: got %h want %h", obs, {8'h00, 3'b001}); end
  endtask

  task automatic test_basic();
    code = 3'd3; hold = 4'd4; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== {8'h08, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL basic_drive c%0d: got %h want %h", i, obs, {8'h08, 3'b100}); end
      tick();
    end
    checks++;
    if (obs !== {8'h00, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_gap: got %h want %h", obs, {8'h00, 3'b110}); end
    tick();
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL basic_idle: got %h want %h", obs, {8'h00, 3'b001}); end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_y;
    hold = 4'd1; code_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      code = 3'(c);
      exp_y = 8'h01 << c;
      #1;
      checks++;
      if (code_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready c%0d: got %b want 1", c, code_ready); end
      tick();
      checks++;
      if (obs !== {exp_y, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL sweep_drive c%0d: got %h want %h", c, obs, {exp_y, 3'b100}); end
      tick();
      checks++;
      if (obs !== {8'h00, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL sweep_gap c%0d: got %h want %h", c, obs, {8'h00, 3'b110}); end
      if (c == 7) code_valid = 1'b0;
      tick();
    end
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL sweep_end_idle: got %h want %h", obs, {8'h00, 3'b001}); end
  endtask

  task automatic test_hold_bounds();
    code = 3'd7; hold = 4'd0; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    checks++;
    if (obs !== {8'h80, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL hold0_drive: got %h want %h", obs, {8'h80, 3'b100}); end
    tick();
    checks++;
    if (obs !== {8'h00, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL hold0_gap: got %h want %h", obs, {8'h00, 3'b110}); end
    tick();
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL hold0_idle: got %h want %h", obs, {8'h00, 3'b001}); end

    code = 3'd1; hold = 4'd15; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (obs !== {8'h02, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL hold15_drive c%0d: got %h want %h", i, obs, {8'h02, 3'b100}); end
      tick();
    end
    checks++;
    if (obs !== {8'h00, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL hold15_gap: got %h want %h", obs, {8'h00, 3'b110}); end
    tick();
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL hold15_idle: got %h want %h", obs, {8'h00, 3'b001}); end
  endtask

  task automatic test_abort();
    code = 3'd5; hold = 4'd8; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== {8'h20, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL abort_drive c%0d: got %h want %h", i, obs, {8'h20, 3'b100}); end
      tick();
    end
    // Third DRIVE cycle: drop enable before the edge.
    enable = 1'b0;
    #1;
    checks++;
    if (obs !== {8'h20, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL abort_drive3: got %h want %h", obs, {8'h20, 3'b100}); end
    tick();
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b0}) begin errors++; $display("FAIL abort_next: got %h want %h", obs, {8'h00, 3'b000}); end
    tick();
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b0}) begin errors++; $display("FAIL abort_hold_off: got %h want %h", obs, {8'h00, 3'b000}); end
    enable = 1'b1;
    #1;
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL abort_reenable: got %h want %h", obs, {8'h00, 3'b001}); end
  endtask

  task automatic test_async_reset();
    code = 3'd2; hold = 4'd6; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    checks++;
    if (obs !== {8'h04, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL areset_drive: got %h want %h", obs, {8'h04, 3'b100}); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b0}) begin errors++; $display("FAIL areset_immediate: got %h want %h", obs, {8'h00, 3'b000}); end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL areset_release: got %h want %h", obs, {8'h00, 3'b001}); end
    code = 3'd4; hold = 4'd2; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== {8'h10, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL areset_new_drive c%0d: got %h want %h", i, obs, {8'h10, 3'b100}); end
      tick();
    end
    checks++;
    if (obs !== {8'h00, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL areset_new_gap: got %h want %h", obs, {8'h00, 3'b110}); end
    tick();
  endtask

  task automatic test_change_during_drive();
    code = 3'd6; hold = 4'd3; code_valid = 1'b1;
    tick();
    // Inputs change and valid stays asserted while the strobe runs.
    code = 3'd0; hold = 4'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== {8'h40, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL chg_drive c%0d: got %h want %h", i, obs, {8'h40, 3'b100}); end
      code = 3'(i + 1);
      tick();
    end
    checks++;
    if (obs !== {8'h00, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL chg_gap: got %h want %h", obs, {8'h00, 3'b110}); end
    code_valid = 1'b0;
    tick();
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL chg_idle: got %h want %h", obs, {8'h00, 3'b001}); end
    tick();
    checks++;
    if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL chg_no_extra: got %h want %h", obs, {8'h00, 3'b001}); end
  endtask

  initial begin
    test_reset();
    tick();
    test_basic();
    test_sweep();
    test_hold_bounds();
    test_abort();
    tick();
    test_async_reset();
    test_change_during_drive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_strobe_decoder.md
# onehot_strobe_decoder

Registered 3-to-8 decoder that consumes 3-bit codes over a valid/ready handshake. Each accepted code drives the matching one-hot strobe on `y` for a programmable number of cycles, then returns `y` to zero. A one-cycle `done` pulse follows each completed strobe. It is the receiving end of the 8-to-3 encoder path: an encoded index arrives, and this block turns it back into a timed one-hot select line.

## Interface
Parameters:
- `HOLD_W`, default 4: width of the hold-length input and the internal hold counter.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `enable`  in  1: block enable; low masks acceptance and aborts an active strobe.
- `code`  in  3: index to decode; 0 maps to `y[0]`, 7 maps to `y[7]`.
- `code_valid`  in  1: `code` and `hold` are valid this cycle.
- `code_ready`  out  1: block can accept a code this cycle.
- `hold`  in  HOLD_W: strobe length N in cycles; 0 is treated as 1.
- `y`  out  8: registered one-hot strobe output; all-zero when idle.
- `busy`  out  1: high while the state is not IDLE.
- `done`  out  1: one-cycle pulse when a strobe completes normally.

## Operation
- State machine has three states: IDLE, DRIVE, GAP.
- IDLE:
  - `y`=0.
  - `code_ready` = `enable` & ~`rst` (combinational).
  - Handshake when `code_valid` & `code_ready` are both high in a cycle.
  - On the handshake edge: latch `code`; load the counter with max(`hold`,1)-1; set `y` <= 1<<`code`; go to DRIVE.
  - `code_valid` without ready: ignored. The source must hold the code until ready.
- DRIVE:
  - `code_ready`=0; `y` stays at the latched one-hot value.
  - Counter nonzero: decrement.
  - Counter zero: `y`<=0, `done`<=1, go to GAP.
  - `enable` low (checked first): `y`<=0, `done` stays 0, counter cleared, go to IDLE (abort).
- GAP:
  - Lasts exactly one cycle: `y`=0, `done`=1, `code_ready`=0.
  - Then `done`<=0 and go to IDLE.
  - `enable` low during GAP has no extra effect; `done` still completes its pulse.
- `code` and `hold` are sampled only at acceptance. Changes during DRIVE have no effect.
- `y` is never multi-hot. It changes only at acceptance, at completion or abort, and at reset.
- Counter width is HOLD_W; the counter never wraps because loading saturates at `hold`=0 → N=1.

## Timing
- Reset values (asynchronous, immediate on `rst`=1): state IDLE, `y`=8'h00, `busy`=0, `done`=0, `code_ready`=0, counter=0.
- Reset mid-strobe: `y` clears in the same cycle without waiting for an edge; no `done`. After `rst` falls, `code_ready` follows `enable` in the same cycle.
- Let t be the handshake cycle and N = max(`hold`,1):
  - `y` is one-hot in cycles t+1 .. t+N (exactly N cycles).
  - `busy` is high in cycles t+1 .. t+N+1.
  - Cycle t+N+1 is GAP: `y`=0, `done`=1.
  - Cycle t+N+2 is IDLE; `code_ready`=1 if `enable` is high.
- Maximum throughput is one code per N+2 cycles. The guaranteed one-cycle all-zero gap separates consecutive strobes.
- Abort: if `enable` is low in DRIVE cycle k, then `y`=0 and the state is IDLE in cycle k+1, and `busy`=0.
- Input-to-output latency is one cycle (handshake cycle → first strobe cycle).

## Test plan
- Reset, then `enable`=1, `code`=3, `hold`=4, `code_valid`=1 for one cycle → `y`=8'h08 for exactly 4 cycles, then `y`=0 with `done`=1 for 1 cycle, then `code_ready`=1.
- Sweep `code` 0..7 with `hold`=1 and `code_valid` held high → `y` = 01,02,04,…,80, each high 1 cycle. Each strobe is separated by a one-cycle zero `y` with a `done` pulse; handshakes occur every 3 cycles.
- `hold`=0, `code`=7 → `y`=8'h80 for exactly 1 cycle (same as `hold`=1). Also `hold`=15 → 15 cycles with no wrap.
- `code`=5, `hold`=8, drop `enable` in the 3rd DRIVE cycle → `y`=0 next cycle, no `done`, `busy`=0, `code_ready`=0 until `enable` returns.
- Assert `rst` asynchronously mid-DRIVE (`code`=2, `hold`=6) → `y`, `busy`, `done` go 0 before the next clock edge. After release, a new code is accepted normally.
- Change `code` and `hold` during DRIVE, and assert `code_valid` while busy → the strobe is unaffected, `code_ready` stays 0, and nothing extra is accepted.
